// File: rtl/pot_scan_sched.sv
// Round-robin A2D scheduler for six slider pots: gap timer, conversion timeout,
// per-slot result registers. Define POT_AVG_EN to average each new result with the old.
module pot_scan_sched #(
    parameter int GAP = 16,
    parameter int TMO = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        sweep_done,
    output logic        all_vld,
    output logic        tmo_err
);

    typedef enum logic {
        WAIT,
        CONV
    } state_t;

    localparam logic [7:0]  GAP_V    = 8'(GAP);
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] tmo_q, tmo_d;
    logic        strt_q, strt_d;
    logic        sweep_q, sweep_d;
    logic        tmo_err_q, tmo_err_d;
    logic [5:0]  wr_q, wr_d;
    logic [11:0] pot_q [6];
    logic [11:0] pot_d [6];
    logic [11:0] wr_val;
    logic        tmo_hit;
    logic        retire;

`ifdef POT_AVG_EN
    logic [11:0] cur_val;
    logic        cur_wr;
    logic [12:0] sum;

    always_comb begin
        cur_val = '0;
        cur_wr  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (slot_q == 3'(i)) begin
                cur_val = pot_q[i];
                cur_wr  = wr_q[i];
            end
        end
        // Rounded mean; an unwritten slot takes the raw result.
        sum    = {1'b0, cur_val} + {1'b0, res} + 13'd1;
        wr_val = cur_wr ? sum[12:1] : res;
    end
`else
    assign wr_val = res;
`endif

    // Completion wins over a timeout landing on the same cycle.
    assign tmo_hit = (tmo_q == TMO_LAST);
    assign retire  = (state_q == CONV) && (cnv_cmplt || tmo_hit);

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        strt_d    = 1'b0;
        sweep_d   = 1'b0;
        tmo_err_d = 1'b0;
        wr_d      = wr_q;
        for (int i = 0; i < 6; i++) begin
            pot_d[i] = pot_q[i];
        end
        unique case (state_q)
            WAIT: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (en) begin
                    strt_d  = 1'b1;
                    state_d = CONV;
                    tmo_d   = '0;
                end
            end
            CONV: begin
                tmo_d = tmo_q + 16'd1;
                if (cnv_cmplt) begin
                    for (int i = 0; i < 6; i++) begin
                        if (slot_q == 3'(i)) begin
                            pot_d[i] = wr_val;
                            wr_d[i]  = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                end
                if (retire) begin
                    state_d = WAIT;
                    gap_d   = GAP_V;
                    sweep_d = (slot_q == 3'd5);
                    slot_d  = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT;
            slot_q    <= 3'd0;
            gap_q     <= GAP_V;
            tmo_q     <= '0;
            strt_q    <= 1'b0;
            sweep_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            wr_q      <= '0;
            for (int i = 0; i < 6; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            strt_q    <= strt_d;
            sweep_q   <= sweep_d;
            tmo_err_q <= tmo_err_d;
            wr_q      <= wr_d;
            for (int i = 0; i < 6; i++) begin
                pot_q[i] <= pot_d[i];
            end
        end
    end

    // ADC128S channel wiring of the six sliders.
    always_comb begin
        chnnl = 3'd1;
        unique case (slot_q)
            3'd0:    chnnl = 3'd1;
            3'd1:    chnnl = 3'd0;
            3'd2:    chnnl = 3'd4;
            3'd3:    chnnl = 3'd2;
            3'd4:    chnnl = 3'd3;
            3'd5:    chnnl = 3'd7;
            default: chnnl = 3'd1;
        endcase
    end

    assign strt_cnv   = strt_q;
    assign sweep_done = sweep_q;
    assign tmo_err    = tmo_err_q;
    assign all_vld    = &wr_q;
    assign POT_LP     = pot_q[0];
    assign POT_B1     = pot_q[1];
    assign POT_B2     = pot_q[2];
    assign POT_B3     = pot_q[3];
    assign POT_HP     = pot_q[4];
    assign VOLUME     = pot_q[5];

endmodule

// File: tb/tb_pot_scan_sched.sv
// Directed bench for pot_scan_sched: scan order, gap/timeout timing,
// enable gating, mid-conversion reset and result write policy.
module tb_pot_scan_sched;

    localparam int GAP = 4;
    localparam int TMO = 64;

`ifdef POT_AVG_EN
    localparam logic [11:0] B3_EN_EXP = 12'h400;
    localparam logic [11:0] LP_2ND    = 12'h401;
`else
    localparam logic [11:0] B3_EN_EXP = 12'h600;
    localparam logic [11:0] LP_2ND    = 12'h001;
`endif

    localparam logic [11:0] SCAN_EXP [6] = '{
        12'h100, 12'h000, 12'h400, 12'h200, 12'h300, 12'h700
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;
    logic        sweep_done;
    logic        all_vld;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  chn;
        int          lat;
        logic [11:0] res;
        int          slot;
        logic [11:0] exp;
        logic        sw;
        logic        vld;
        int          gw;
    } rec_t;

    rec_t tbl [12];

    pot_scan_sched #(.GAP(GAP), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .strt_cnv   (strt_cnv),
        .chnnl      (chnnl),
        .cnv_cmplt  (cnv_cmplt),
        .res        (res),
        .POT_LP     (POT_LP),
        .POT_B1     (POT_B1),
        .POT_B2     (POT_B2),
        .POT_B3     (POT_B3),
        .POT_HP     (POT_HP),
        .VOLUME     (VOLUME),
        .sweep_done (sweep_done),
        .all_vld    (all_vld),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] pot_of(input int s);
        case (s)
            0:       return POT_LP;
            1:       return POT_B1;
            2:       return POT_B2;
            3:       return POT_B3;
            4:       return POT_HP;
            default: return VOLUME;
        endcase
    endfunction

    task automatic wait_strt(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!strt_cnv && n < 300);
    endtask

    task automatic finish_conv(input rec_t v);
        int n;
        if (v.lat < 0) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (!tmo_err && n < 300);
            chk("tmo_cycle", 32'(n), 32'(TMO));
        end else begin
            for (int i = 0; i < v.lat; i++) begin
                cyc();
                if (i == 0) chk("strt_one_cycle", 32'(strt_cnv), 32'(0));
            end
            chk("chnnl_at_cmplt", 32'(chnnl), 32'(v.chn));
            cnv_cmplt = 1'b1;
            res       = v.res;
            cyc();
            cnv_cmplt = 1'b0;
            chk("no_tmo_on_cmplt", 32'(tmo_err), 32'(0));
        end
        chk("pot_value", 32'(pot_of(v.slot)), 32'(v.exp));
        chk("sweep_done", 32'(sweep_done), 32'(v.sw));
        chk("all_vld", 32'(all_vld), 32'(v.vld));
    endtask

    task automatic run_rec(input rec_t v);
        int n;
        wait_strt(n);
        chk("strt_gap", 32'(n), 32'(v.gw));
        chk("chnnl_at_strt", 32'(chnnl), 32'(v.chn));
        finish_conv(v);
    endtask

    initial begin
        int n;
        int cnt;
        // first sweep: slot 2 times out
        tbl[0]  = '{3'd1, 20, 12'h100, 0, 12'h100, 1'b0, 1'b0, GAP + 1};
        tbl[1]  = '{3'd0, 20, 12'h000, 1, 12'h000, 1'b0, 1'b0, GAP + 1};
        tbl[2]  = '{3'd4, -1, 12'h000, 2, 12'h000, 1'b0, 1'b0, GAP + 1};
        tbl[3]  = '{3'd2, 20, 12'h200, 3, 12'h200, 1'b0, 1'b0, GAP + 1};
        tbl[4]  = '{3'd3, 20, 12'h300, 4, 12'h300, 1'b0, 1'b0, GAP + 1};
        tbl[5]  = '{3'd7, 20, 12'h700, 5, 12'h700, 1'b1, 1'b0, GAP + 1};
        // second sweep: immediate and last-cycle completions
        tbl[6]  = '{3'd1, 0,  12'h100, 0, 12'h100, 1'b0, 1'b0, GAP + 1};
        tbl[7]  = '{3'd0, 63, 12'h000, 1, 12'h000, 1'b0, 1'b0, GAP + 1};
        tbl[8]  = '{3'd4, 20, 12'h400, 2, 12'h400, 1'b0, 1'b1, GAP + 1};
        tbl[9]  = '{3'd2, 20, 12'h200, 3, 12'h200, 1'b0, 1'b1, GAP + 1};
        tbl[10] = '{3'd3, 20, 12'h300, 4, 12'h300, 1'b0, 1'b1, GAP + 1};
        tbl[11] = '{3'd7, 20, 12'h700, 5, 12'h700, 1'b1, 1'b1, GAP + 1};

        rst       = 1'b1;
        en        = 1'b0;
        cnv_cmplt = 1'b0;
        res       = '0;
        repeat (3) cyc();
        chk("rst_strt", 32'(strt_cnv), 32'(0));
        chk("rst_chnnl", 32'(chnnl), 32'(1));
        for (int i = 0; i < 6; i++) chk("rst_pot", 32'(pot_of(i)), 32'(0));
        chk("rst_sweep", 32'(sweep_done), 32'(0));
        chk("rst_all_vld", 32'(all_vld), 32'(0));
        chk("rst_tmo", 32'(tmo_err), 32'(0));
        en = 1'b1;
        cyc();
        chk("rst_hold_strt", 32'(strt_cnv), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_rec(tbl[i]);

        for (int i = 0; i < 6; i++) chk("scan_final", 32'(pot_of(i)), 32'(SCAN_EXP[i]));
        cyc();
        chk("sweep_one_cycle", 32'(sweep_done), 32'(0));

        // enable dropped during the POT_B3 conversion
        run_rec('{3'd1, 20, 12'h100, 0, 12'h100, 1'b0, 1'b1, GAP});
        run_rec('{3'd0, 20, 12'h000, 1, 12'h000, 1'b0, 1'b1, GAP + 1});
        run_rec('{3'd4, 20, 12'h400, 2, 12'h400, 1'b0, 1'b1, GAP + 1});
        wait_strt(n);
        chk("en_strt_gap", 32'(n), 32'(GAP + 1));
        chk("en_b3_chnnl", 32'(chnnl), 32'(2));
        en = 1'b0;
        finish_conv('{3'd2, 10, 12'h600, 3, B3_EN_EXP, 1'b0, 1'b1, 0});
        cnt = 0;
        repeat (30) begin
            cyc();
            if (strt_cnv) cnt++;
        end
        chk("en_low_no_strt", 32'(cnt), 32'(0));
        chk("en_low_chnnl", 32'(chnnl), 32'(3));
        en = 1'b1;
        wait_strt(n);
        chk("reen_latency", 32'(n), 32'(1));
        chk("reen_chnnl", 32'(chnnl), 32'(3));
        finish_conv('{3'd3, 20, 12'h300, 4, 12'h300, 1'b0, 1'b1, 0});
        run_rec('{3'd7, 20, 12'h700, 5, 12'h700, 1'b1, 1'b1, GAP + 1});

        // one-cycle reset mid-conversion, then a stray completion
        wait_strt(n);
        chk("pre_rst_gap", 32'(n), 32'(GAP + 1));
        chk("pre_rst_chnnl", 32'(chnnl), 32'(1));
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        cyc();
        cnv_cmplt = 1'b0;
        for (int i = 0; i < 6; i++) chk("stray_pot", 32'(pot_of(i)), 32'(0));
        chk("stray_all_vld", 32'(all_vld), 32'(0));
        chk("stray_sweep", 32'(sweep_done), 32'(0));
        chk("stray_tmo", 32'(tmo_err), 32'(0));
        chk("stray_strt", 32'(strt_cnv), 32'(0));
        chk("stray_chnnl", 32'(chnnl), 32'(1));
        wait_strt(n);
        chk("post_rst_gap", 32'(n), 32'(GAP));
        chk("post_rst_chnnl", 32'(chnnl), 32'(1));

        // two POT_LP results: 0x800 then 0x001
        finish_conv('{3'd1, 10, 12'h800, 0, 12'h800, 1'b0, 1'b0, 0});
        run_rec('{3'd0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, GAP + 1});
        run_rec('{3'd4, 0, 12'h000, 2, 12'h000, 1'b0, 1'b0, GAP + 1});
        run_rec('{3'd2, 0, 12'h000, 3, 12'h000, 1'b0, 1'b0, GAP + 1});
        run_rec('{3'd3, 0, 12'h000, 4, 12'h000, 1'b0, 1'b0, GAP + 1});
        run_rec('{3'd7, 0, 12'h000, 5, 12'h000, 1'b1, 1'b1, GAP + 1});
        run_rec('{3'd1, 5, 12'h001, 0, LP_2ND, 1'b0, 1'b1, GAP + 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
